// File: rtl/button_edge_conditioner.sv
// Per-channel synchroniser, debounce, mode-selectable edge strobe and optional hold-to-repeat.
// level/pulse update SYNC_STAGES+DB_CYCLES-1 edges after a clean input change; no backpressure.
module button_edge_conditioner #(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sig,
  input  logic [1:0]      edge_mode,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] pulse,
  output logic            any_pulse
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [N_CH-1:0] pulse_nxt;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sff;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   lvl;
    logic                   lvl_nxt;
    logic                   sync;
    logic                   flip;
    logic                   rise;
    logic                   fall;
    logic                   rpt_hit;

    assign sync     = sff[SYNC_STAGES-1];
    assign level[c] = lvl;

    always_comb begin
      cnt_nxt = '0;
      lvl_nxt = lvl;
      flip    = 1'b0;
      if (sync != lvl) begin
        if (cnt == CNT_LAST) begin
          flip    = 1'b1;
          lvl_nxt = sync;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end

    assign rise = flip & lvl_nxt;
    assign fall = flip & ~lvl_nxt;

    if (REPEAT_DELAY > 0) begin : g_rpt
      localparam int            RW         = $clog2(REPEAT_DELAY + 1);
      localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_DELAY);
      localparam logic [RW-1:0] RPT_RELOAD =
        RW'((REPEAT_DELAY > REPEAT_PERIOD) ? (REPEAT_DELAY - REPEAT_PERIOD) : 0);

      logic [RW-1:0] rpt;
      logic [RW-1:0] rpt_inc;
      logic [RW-1:0] rpt_nxt;

      // rpt never exceeds REPEAT_DELAY-1 between hits, so rpt_inc cannot wrap
      always_comb begin
        rpt_inc = rpt + RW'(1);
        rpt_nxt = '0;
        rpt_hit = 1'b0;
        if (lvl && !flip) begin
          if (rpt_inc == RPT_FIRE) begin
            rpt_hit = 1'b1;
            rpt_nxt = RPT_RELOAD;
          end else begin
            rpt_nxt = rpt_inc;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) rpt <= '0;
        else     rpt <= rpt_nxt;
      end
    end else begin : g_norpt
      assign rpt_hit = 1'b0;
    end

    assign pulse_nxt[c] = (edge_mode == 2'b00) ? (rise | rpt_hit) :
                          (edge_mode == 2'b01) ? fall :
                          (edge_mode == 2'b10) ? (flip | rpt_hit) : 1'b0;

    always_ff @(posedge clk) begin
      if (rst) begin
        sff <= '0;
        cnt <= '0;
        lvl <= 1'b0;
      end else begin
        sff <= {sff[SYNC_STAGES-2:0], sig[c]};
        cnt <= cnt_nxt;
        lvl <= lvl_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse     <= '0;
      any_pulse <= 1'b0;
    end else begin
      pulse     <= pulse_nxt;
      any_pulse <= |pulse_nxt;
    end
  end

endmodule

// File: tb/tb_button_edge_conditioner.sv
// Directed bench: dut_a has repeat disabled, dut_b has REPEAT_DELAY=20/PERIOD=8; both DB_CYCLES=4.
module tb_button_edge_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sig;
  logic [1:0] edge_mode;
  logic [3:0] level_a, pulse_a, level_b, pulse_b;
  logic       any_a, any_b;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  button_edge_conditioner #(
    .N_CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(8)
  ) dut_a (
    .clk(clk), .rst(rst), .sig(sig), .edge_mode(edge_mode),
    .level(level_a), .pulse(pulse_a), .any_pulse(any_a)
  );

  button_edge_conditioner #(
    .N_CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut_b (
    .clk(clk), .rst(rst), .sig(sig), .edge_mode(edge_mode),
    .level(level_b), .pulse(pulse_b), .any_pulse(any_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] el, input logic [3:0] ep, input logic ea);
    nvec++;
    assert (level_a === el) else begin
      nerr++;
      $error("FAIL %s level got %b expected %b", tag, level_a, el);
    end
    assert (pulse_a === ep) else begin
      nerr++;
      $error("FAIL %s pulse got %b expected %b", tag, pulse_a, ep);
    end
    assert (any_a === ea) else begin
      nerr++;
      $error("FAIL %s any_pulse got %b expected %b", tag, any_a, ea);
    end
  endtask

  task automatic chkr(input string tag, input logic [3:0] el, input logic [3:0] ep, input logic ea);
    nvec++;
    assert (level_b === el) else begin
      nerr++;
      $error("FAIL %s level got %b expected %b", tag, level_b, el);
    end
    assert (pulse_b === ep) else begin
      nerr++;
      $error("FAIL %s pulse got %b expected %b", tag, pulse_b, ep);
    end
    assert (any_b === ea) else begin
      nerr++;
      $error("FAIL %s any_pulse got %b expected %b", tag, any_b, ea);
    end
  endtask

  // Press then release the channels in mask; rise/fall select which edges must strobe.
  task automatic press_release(input string tag, input logic [1:0] m, input logic [3:0] mask,
                               input logic r, input logic f);
    edge_mode = m;
    sig = mask;
    for (int i = 0; i < 5; i++) begin
      step();
      chk({tag, "_pre"}, 4'b0000, 4'b0000, 1'b0);
    end
    step();
    chk({tag, "_rise"}, mask, r ? mask : 4'b0000, r);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({tag, "_hold"}, mask, 4'b0000, 1'b0);
    end
    sig = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk({tag, "_rel"}, mask, 4'b0000, 1'b0);
    end
    step();
    chk({tag, "_fall"}, 4'b0000, f ? mask : 4'b0000, f);
    step();
    chk({tag, "_after"}, 4'b0000, 4'b0000, 1'b0);
    edge_mode = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    sig = 4'b0000;
    edge_mode = 2'b00;
    repeat (3) step();
    chk("reset", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    repeat (3) step();
    chk("idle", 4'b0000, 4'b0000, 1'b0);

    // Clean press on ch0: sampled at edge E, level/pulse at E+5 only
    sig = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s1_lat", 4'b0000, 4'b0000, 1'b0);
    end
    step();
    chk("s1_pulse", 4'b0001, 4'b0001, 1'b1);
    step();
    chk("s1_single", 4'b0001, 4'b0000, 1'b0);
    sig = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s1_rel", 4'b0001, 4'b0000, 1'b0);
    end
    step();
    chk("s1_fall_nopulse", 4'b0000, 4'b0000, 1'b0);

    // Three-sample glitch on ch1 must never reach level
    sig = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s2_glitch_hi", 4'b0000, 4'b0000, 1'b0);
    end
    sig = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("s2_glitch_lo", 4'b0000, 4'b0000, 1'b0);
    end

    press_release("s3_m00", 2'b00, 4'b0100, 1'b1, 1'b0);
    press_release("s3_m01", 2'b01, 4'b0100, 1'b0, 1'b1);
    press_release("s3_m10", 2'b10, 4'b0100, 1'b1, 1'b1);
    press_release("s3_m11", 2'b11, 4'b0100, 1'b0, 1'b0);

    // Hold-to-repeat on ch3 (dut_b): press at P, repeats at P+20, P+28, ...
    sig = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      step();
      chkr("s4_pre", 4'b0000, 4'b0000, 1'b0);
    end
    step();
    chkr("s4_press", 4'b1000, 4'b1000, 1'b1);
    for (int k = 1; k <= 90; k++) begin
      logic exp_p;
      if (k == 61) sig = 4'b0000;
      step();
      exp_p = (k >= 20) && (k <= 65) && (((k - 20) % 8) == 0);
      chkr("s4_repeat", (k <= 65) ? 4'b1000 : 4'b0000, exp_p ? 4'b1000 : 4'b0000, exp_p);
    end

    // Reset during ch0 debounce with input held high
    sig = 4'b0001;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("s5_in_reset", 4'b0000, 4'b0000, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s5_post_reset", 4'b0000, 4'b0000, 1'b0);
    end
    step();
    chk("s5_pulse", 4'b0001, 4'b0001, 1'b1);
    step();
    chk("s5_single", 4'b0001, 4'b0000, 1'b0);
    sig = 4'b0000;
    repeat (8) step();
    chk("s5_released", 4'b0000, 4'b0000, 1'b0);

    press_release("s6_all", 2'b00, 4'b1111, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
